// File: rtl/led_pwm_bank.sv
// Multi-channel LED PWM stage: per-channel duty scaled by a global brightness,
// double-buffered so new settings only take effect at PWM period boundaries.
module led_pwm_bank #(
  parameter int CHANNELS = 8,
  parameter int PRESCALE = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [8*CHANNELS-1:0] duty,
  input  logic [7:0]            brightness,
  input  logic                  duty_valid,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  period_start,
  output logic                  load_done
);

  localparam logic [15:0] PS_LAST    = 16'(PRESCALE - 1);
  localparam logic [7:0]  PHASE_LAST = 8'd254;

  logic [15:0]                 prescaler;
  logic [7:0]                  phase;
  logic                        tick;
  logic                        boundary;
  logic [8*CHANNELS-1:0]       pend_duty;
  logic [7:0]                  pend_bright;
  logic                        pend_flag;
  logic [CHANNELS-1:0][7:0]    eff;
  logic [CHANNELS-1:0][7:0]    scaled;

  assign tick     = (prescaler == PS_LAST);
  assign boundary = tick && (phase == PHASE_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prescaler <= '0;
      phase     <= '0;
    end else if (tick) begin
      prescaler <= '0;
      phase     <= (phase == PHASE_LAST) ? 8'd0 : phase + 8'd1;
    end else begin
      prescaler <= prescaler + 16'd1;
    end
  end

  // A strobe in the boundary cycle refills the buffer and keeps the flag set,
  // while the transfer below still consumes the previous contents.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_duty   <= '0;
      pend_bright <= '0;
      pend_flag   <= 1'b0;
    end else if (duty_valid) begin
      pend_duty   <= duty;
      pend_bright <= brightness;
      pend_flag   <= 1'b1;
    end else if (boundary) begin
      pend_flag   <= 1'b0;
    end
  end

  always_comb begin
    logic [16:0] prod;
    scaled = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      prod      = 17'(pend_duty[8*i +: 8]) * 17'({1'b0, pend_bright} + 9'd1);
      scaled[i] = 8'(prod >> 8);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      eff          <= '0;
      load_done    <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
      load_done    <= boundary && pend_flag;
      if (boundary && pend_flag) begin
        eff <= scaled;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= (phase < eff[i]);
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Bench for led_pwm_bank: expected per-period high counts and load pulses are
// queued as stimulus is planned and compared after each measured period.
module tb_led_pwm_bank;

  localparam int CH  = 4;
  localparam int P   = 3;
  localparam int PER = 255 * P;

  logic            CLK = 1'b0;
  logic            RST;
  logic [8*CH-1:0] duty;
  logic [7:0]      brightness;
  logic            duty_valid;
  logic [CH-1:0]   pwm_out;
  logic            period_start;
  logic            load_done;

  int checkCount = 0;
  int passCount  = 0;

  string            tag_q[$];
  logic [CH*16-1:0] hi_q[$];
  int               load_q[$];

  led_pwm_bank #(.CHANNELS(CH), .PRESCALE(P)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .duty         (duty),
    .brightness   (brightness),
    .duty_valid   (duty_valid),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .load_done    (load_done)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input int obs, input int exp_v);
    checkCount++;
    if (obs == exp_v) passCount++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
  endtask

  // Idle cycles scramble the data inputs so only strobed values can be captured.
  task automatic applyStimulus(input logic valid, input logic [8*CH-1:0] d, input logic [7:0] b);
    duty_valid = valid;
    if (valid) begin
      duty       = d;
      brightness = b;
    end else begin
      duty       = $urandom;
      brightness = 8'($urandom);
    end
  endtask

  function automatic logic [8*CH-1:0] pack(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic pushExpect(input string tag, input int e0, input int e1, input int e2,
                            input int e3, input int loads);
    logic [CH*16-1:0] v;
    v = {16'(e3 * P), 16'(e2 * P), 16'(e1 * P), 16'(e0 * P)};
    tag_q.push_back(tag);
    hi_q.push_back(v);
    load_q.push_back(loads);
  endtask

  // Called at the period_start cycle; returns at the next one.
  task automatic measurePeriod(input int s1At, input logic [8*CH-1:0] s1Duty, input logic [7:0] s1Bright,
                               input int s2At, input logic [8*CH-1:0] s2Duty, input logic [7:0] s2Bright);
    int               hi[CH];
    int               loads;
    string            tag;
    logic [CH*16-1:0] v;
    for (int c = 0; c < CH; c++) hi[c] = 0;
    loads = int'(load_done);
    for (int i = 1; i <= PER; i++) begin
      @(negedge CLK);
      for (int c = 0; c < CH; c++) hi[c] += int'(pwm_out[c]);
      if (i < PER) loads += int'(load_done);
      if (i == s1At)      applyStimulus(1'b1, s1Duty, s1Bright);
      else if (i == s2At) applyStimulus(1'b1, s2Duty, s2Bright);
      else                applyStimulus(1'b0, '0, '0);
    end
    checkOutput("period_len", int'(period_start), 1);
    if (tag_q.size() == 0) begin
      checkOutput("sb_underflow", tag_q.size(), 1);
    end else begin
      tag = tag_q.pop_front();
      v   = hi_q.pop_front();
      for (int c = 0; c < CH; c++)
        checkOutput($sformatf("%s_ch%0d", tag, c), hi[c], int'(v[16*c +: 16]));
      checkOutput({tag, "_loads"}, loads, load_q.pop_front());
    end
  endtask

  task automatic waitFirstStart(input string tag);
    int k;
    k = 0;
    while (!period_start && k < 2 * PER) begin
      @(negedge CLK);
      applyStimulus(1'b0, '0, '0);
      k++;
    end
    checkOutput(tag, k, PER);
    checkOutput({tag, "_load"}, int'(load_done), 0);
  endtask

  initial begin
    logic [CH+1:0] orAcc;
    RST        = 1'b1;
    duty       = '0;
    brightness = '0;
    duty_valid = 1'b0;
    orAcc      = '0;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'(i % 2), pack(255, 255, 255, 255), 8'd255);
      @(negedge CLK);
      orAcc |= {pwm_out, period_start, load_done};
    end
    checkOutput("reset_hold", int'(orAcc), 0);
    applyStimulus(1'b0, '0, '0);
    RST = 1'b0;
    waitFirstStart("first_start");

    pushExpect("idle", 0, 0, 0, 0, 0);
    measurePeriod(10, pack(0, 255, 128, 1), 8'd255, -1, '0, '0);
    pushExpect("extremes", 0, 255, 128, 1, 1);
    measurePeriod(10, pack(200, 255, 1, 100), 8'd127, -1, '0, '0);
    pushExpect("scale", 100, 127, 0, 50, 1);
    measurePeriod(10, pack(255, 255, 255, 255), 8'd0, -1, '0, '0);
    pushExpect("bright0", 0, 0, 0, 0, 1);
    measurePeriod(20, pack(50, 50, 50, 50), 8'd255, 400, pack(90, 90, 90, 90), 8'd255);
    pushExpect("lastwins", 90, 90, 90, 90, 1);
    measurePeriod(PER - 1, pack(60, 60, 60, 60), 8'd255, -1, '0, '0);
    pushExpect("coinc_clear", 90, 90, 90, 90, 0);
    measurePeriod(-1, '0, '0, -1, '0, '0);
    pushExpect("coinc_late", 60, 60, 60, 60, 1);
    measurePeriod(100, pack(40, 40, 40, 40), 8'd255, PER - 1, pack(70, 70, 70, 70), 8'd255);
    pushExpect("coinc_old", 40, 40, 40, 40, 1);
    measurePeriod(-1, '0, '0, -1, '0, '0);
    pushExpect("coinc_new", 70, 70, 70, 70, 1);
    measurePeriod(-1, '0, '0, -1, '0, '0);

    applyStimulus(1'b1, pack(100, 100, 100, 100), 8'd255);
    @(negedge CLK);
    applyStimulus(1'b0, '0, '0);
    repeat (49) @(negedge CLK);
    checkOutput("pre_reset_pwm", int'(pwm_out), 15);
    RST = 1'b1;
    #1;
    checkOutput("async_rst_pwm", int'(pwm_out), 0);
    checkOutput("async_rst_flags", int'({period_start, load_done}), 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    waitFirstStart("restart_start");
    pushExpect("after_rst_a", 0, 0, 0, 0, 0);
    measurePeriod(-1, '0, '0, -1, '0, '0);
    pushExpect("after_rst_b", 0, 0, 0, 0, 0);
    measurePeriod(-1, '0, '0, -1, '0, '0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
